shield_pipe_slice: RTL

Parametrised, fully pipelined valid/ready register slice. It replaces bare enable registers on long shield datapaths (AXI-stream payloads, crypto-engine beats) where timing closure needs registered outputs in both directions. It chains DEPTH identical two-entry skid stages. This gives one beat per cycle of throughput, a registered s_ready, and a registered m_valid/m_data.

---
 rtl/shield_pipe_slice_pkg.sv | 9 +
 rtl/shield_skid_stage.sv | 82 ++++++++
 rtl/shield_pipe_slice.sv | 60 ++++++
 3 files changed

// File: rtl/shield_pipe_slice_pkg.sv
// Shared defaults for the shield pipe slice and its skid stages.
// Latency DEPTH cycles; backpressure registered per stage, no m_ready->s_ready path.
package shield_pipe_slice_pkg;

  localparam int SPS_WIDTH_DEFAULT      = 32;
  localparam int SPS_DEPTH_DEFAULT      = 1;
  localparam int SPS_RESET_DATA_DEFAULT = 0;

endpackage

// File: rtl/shield_skid_stage.sv
// One two-entry skid stage: registered out_valid/out_data and registered in_ready.
// Latency 1 cycle; in_ready drops only when the skid entry is occupied.
module shield_skid_stage
  import shield_pipe_slice_pkg::*;
#(
  parameter int WIDTH      = SPS_WIDTH_DEFAULT,
  parameter int RESET_DATA = SPS_RESET_DATA_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // State is {skid_valid, main_valid}; skid without main is illegal.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic [1:0]       state;
  logic             in_xfer;
  logic             out_xfer;

  assign state     = {skid_valid, main_valid};
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign busy      = main_valid | skid_valid;
  assign in_xfer   = in_valid & ~skid_valid;
  assign out_xfer  = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      if (RESET_DATA != 0) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_data <= in_data;
          end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
          end else if (out_xfer) begin
            main_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // Skid entry is older than anything upstream, so it refills main.
          if (out_xfer) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shield_pipe_slice.sv
// DEPTH chained skid stages giving a fully registered valid/ready slice, 2*DEPTH beats deep.
// Latency DEPTH cycles; s_ready is registered and forced low during reset; DEPTH=0 is a wire.
module shield_pipe_slice
  import shield_pipe_slice_pkg::*;
#(
  parameter int WIDTH      = SPS_WIDTH_DEFAULT,
  parameter int DEPTH      = SPS_DEPTH_DEFAULT,
  parameter int RESET_DATA = SPS_RESET_DATA_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign s_ready = m_ready;
      assign m_valid = s_valid;
      assign m_data  = s_data;
      assign busy    = 1'b0;
    end else begin : g_pipe
      logic             vld [0:DEPTH];
      logic             rdy [0:DEPTH];
      logic [WIDTH-1:0] dat [0:DEPTH];
      logic [DEPTH-1:0] stage_busy;

      assign vld[0]     = s_valid;
      assign dat[0]     = s_data;
      assign s_ready    = rdy[0] & ~rst;
      assign rdy[DEPTH] = m_ready;
      assign m_valid    = vld[DEPTH];
      assign m_data     = dat[DEPTH];
      assign busy       = |stage_busy;

      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        shield_skid_stage #(
          .WIDTH      (WIDTH),
          .RESET_DATA (RESET_DATA)
        ) u_stage (
          .clk       (clk),
          .rst       (rst),
          .in_valid  (vld[i]),
          .in_ready  (rdy[i]),
          .in_data   (dat[i]),
          .out_valid (vld[i+1]),
          .out_ready (rdy[i+1]),
          .out_data  (dat[i+1]),
          .busy      (stage_busy[i])
        );
      end
    end
  endgenerate

endmodule
